// File: rtl/video_axis_pkg.sv
// video_axis_pkg: shared types and constants for the AXI4-Stream video sink checker.
package video_axis_pkg;

    typedef enum logic {HUNT, ACTIVE} state_t;

    localparam int ERR_EARLY_EOL    = 0;
    localparam int ERR_MISSING_EOL  = 1;
    localparam int ERR_SOF_MIDFRAME = 2;
    localparam int ERR_MISSING_SOF  = 3;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/lfsr_backpressure.sv
// lfsr_backpressure: 16-bit LFSR whose low two bits give a ~75% duty ready hint.
module lfsr_backpressure
    import video_axis_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic ready_bit
);

    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst)
            lfsr <= SEED;
        else if (enable)
            lfsr <= lfsr_next(lfsr);
    end

    assign ready_bit = lfsr[0] | lfsr[1];

endmodule

// File: rtl/stream_video_sink_checker.sv
// stream_video_sink_checker: AXI4-Stream video sink that checks framing against a fixed
// geometry and reports sticky errors, counters and a per-frame checksum.
module stream_video_sink_checker
    import video_axis_pkg::*;
#(
    parameter int          DATA_WIDTH    = 24,
    parameter int          FRAME_WIDTH   = 20,
    parameter int          FRAME_HEIGHT  = 10,
    parameter int          CNT_WIDTH     = 12,
    parameter int          BP_ENABLE     = 0,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    s_axis_video_tdata,
    input  logic                     s_axis_video_tvalid,
    output logic                     s_axis_video_tready,
    input  logic                     s_axis_video_tuser,
    input  logic                     s_axis_video_tlast,
    input  logic                     enable,
    input  logic                     clear_errors,
    output logic                     locked,
    output logic [CNT_WIDTH-1:0]     pixel_x,
    output logic [CNT_WIDTH-1:0]     pixel_y,
    output logic                     frame_done,
    output logic [31:0]              frame_count,
    output logic [31:0]              frame_checksum,
    output logic [3:0]               err_flags,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam logic [CNT_WIDTH-1:0] X_LAST = CNT_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] Y_LAST = CNT_WIDTH'(FRAME_HEIGHT - 1);

    state_t      state;
    logic [31:0] acc;
    logic [31:0] pix;
    logic [31:0] sum;
    logic        ready_bit;
    logic        beat;
    logic        origin;
    logic        x_last;
    logic        y_last;
    logic        eol;
    logic        err_any;
    logic [3:0]  err_new;

    lfsr_backpressure #(.SEED(LFSR_SEED)) u_bp (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .ready_bit (ready_bit)
    );

    assign beat    = s_axis_video_tvalid & s_axis_video_tready;
    assign origin  = (pixel_x == '0) && (pixel_y == '0);
    assign x_last  = pixel_x == X_LAST;
    assign y_last  = pixel_y == Y_LAST;
    assign eol     = s_axis_video_tlast | x_last;
    assign pix     = 32'(s_axis_video_tdata);
    // The accumulator restarts at the first pixel of each frame rather than being cleared at frame end.
    assign sum     = (origin ? 32'd0 : acc) + pix;
    assign err_any = |err_new;

    // One error event per beat, highest priority first.
    always_comb begin
        err_new = '0;
        if (beat && state == ACTIVE) begin
            if (s_axis_video_tuser && !origin)
                err_new[ERR_SOF_MIDFRAME] = 1'b1;
            else if (!s_axis_video_tuser && origin)
                err_new[ERR_MISSING_SOF] = 1'b1;
            else if (s_axis_video_tlast && !x_last)
                err_new[ERR_EARLY_EOL] = 1'b1;
            else if (!s_axis_video_tlast && x_last)
                err_new[ERR_MISSING_EOL] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state               <= HUNT;
            locked              <= 1'b0;
            s_axis_video_tready <= 1'b0;
            pixel_x             <= '0;
            pixel_y             <= '0;
            acc                 <= '0;
            frame_done          <= 1'b0;
            frame_count         <= '0;
            frame_checksum      <= '0;
            err_flags           <= '0;
            err_count           <= '0;
        end else begin
            s_axis_video_tready <= enable & ((BP_ENABLE != 0) ? ready_bit : 1'b1);
            frame_done          <= 1'b0;
            err_flags           <= (clear_errors ? 4'd0 : err_flags) | err_new;
            err_count           <= clear_errors ? ERR_CNT_WIDTH'(err_any)
                                 : err_count + ERR_CNT_WIDTH'(err_any && !(&err_count));
            if (beat) begin
                if (state == HUNT || (s_axis_video_tuser && !origin)) begin
                    if (s_axis_video_tuser) begin
                        state   <= ACTIVE;
                        locked  <= 1'b1;
                        pixel_x <= CNT_WIDTH'(1);
                        pixel_y <= '0;
                        acc     <= pix;
                    end
                end else if (origin && !s_axis_video_tuser) begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end else if (!eol) begin
                    pixel_x <= pixel_x + CNT_WIDTH'(1);
                    acc     <= sum;
                end else if (y_last) begin
                    pixel_x        <= '0;
                    pixel_y        <= '0;
                    frame_done     <= 1'b1;
                    frame_count    <= frame_count + 32'd1;
                    frame_checksum <= sum;
                end else begin
                    pixel_x <= '0;
                    pixel_y <= pixel_y + CNT_WIDTH'(1);
                    acc     <= sum;
                end
            end
        end
    end

endmodule
